// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and pipeline-control outputs of pipe_ctrl.
// master = the controller, slave = the datapath it steers.
interface pipe_ctrl_if #(parameter int REG_BITS = 4);
  logic [REG_BITS-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_load, ex_mdu, mdu_done, branch_taken, stop;
  logic pc_en, ifid_en, idex_en, exma_en, marw_en;
  logic ifid_flush, idex_flush, exma_bubble, halted;
  logic [15:0] stall_cnt;
  modport master (
    input  id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_load, ex_mdu,
           mdu_done, branch_taken, stop,
    output pc_en, ifid_en, idex_en, exma_en, marw_en, ifid_flush, idex_flush,
           exma_bubble, halted, stall_cnt
  );
  modport slave (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_load, ex_mdu,
           mdu_done, branch_taken, stop,
    input  pc_en, ifid_en, idex_en, exma_en, marw_en, ifid_flush, idex_flush,
           exma_bubble, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush/drain controller.
// Define PIPE_CTRL_PERF_EN to build the saturating stall_cnt perf counter.
module pipe_ctrl #(
  parameter int REG_BITS     = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.master bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, MDU, DRAIN, HALT} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_BITS-1:0] rs1, rs2, rd;
  logic hazard, mdu_wait;
  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;
  assign hazard   = bus.ex_load & ((bus.id_use_rs1 & (rs1 == rd)) | (bus.id_use_rs2 & (rs2 == rd)));
  assign mdu_wait = bus.ex_mdu & ~bus.mdu_done;
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.idex_en     = 1'b1;
    bus.exma_en     = 1'b1;
    bus.marw_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exma_bubble = 1'b0;
    bus.halted      = 1'b0;
    if (state_q == HALT) begin
      bus.pc_en   = 1'b0;
      bus.ifid_en = 1'b0;
      bus.idex_en = 1'b0;
      bus.exma_en = 1'b0;
      bus.marw_en = 1'b0;
      bus.halted  = 1'b1;
      state_d     = bus.stop ? HALT : RUN;
    end else begin
      if (mdu_wait) begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idex_en     = 1'b0;
        bus.exma_bubble = 1'b1;
      end else if (bus.branch_taken) begin
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end else if (hazard) begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
      end
      // Draining keeps fetch shut while downstream stages still obey stalls.
      if (state_q == DRAIN) begin
        bus.pc_en      = 1'b0;
        bus.ifid_flush = 1'b1;
        if (!mdu_wait) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == CW'(1)) ? HALT : DRAIN;
        end
      end else if (mdu_wait) begin
        state_d = MDU;
      end else if (bus.stop) begin
        state_d = DRAIN;
        cnt_d   = CW'(DRAIN_CYCLES);
      end else begin
        state_d = RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (!bus.pc_en && state_q != HALT && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, directed corner sequences and random stimulus
// checked against a rule-level model of the pipeline controller.
module tb_pipe_ctrl;
  localparam int DC = 4;
  localparam logic [8:0] N  = 9'b111110000;
  localparam logic [8:0] HZ = 9'b001110100;
  localparam logic [8:0] BR = 9'b111111100;
  localparam logic [8:0] MW = 9'b000110010;
  localparam logic [8:0] DR = 9'b011111000;
  localparam logic [8:0] HL = 9'b000000001;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int m_drain = 0;
  bit m_halt = 1'b0;
  int m_cnt = 0;
  pipe_ctrl_if #(.REG_BITS(4)) bus ();
  pipe_ctrl #(.REG_BITS(4), .DRAIN_CYCLES(DC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic ld, mdu, done, br, u1, u2;
    logic [3:0] rs1, rs2, rd;
    logic [8:0] exp;
  } vec_t;
  function automatic logic [8:0] dut_out();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exma_en, bus.marw_en,
            bus.ifid_flush, bus.idex_flush, bus.exma_bubble, bus.halted};
  endfunction
  function automatic logic [8:0] model_out();
    logic [8:0] o;
    bit w, haz;
    if (m_halt) return HL;
    w   = bus.ex_mdu && !bus.mdu_done;
    haz = bus.ex_load && ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                          (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    o = w ? MW : bus.branch_taken ? BR : haz ? HZ : N;
    if (m_drain > 0) begin
      o[8] = 1'b0;
      o[3] = 1'b1;
    end
    return o;
  endfunction
  task automatic model_tick();
    logic [8:0] o;
    bit w;
    o = model_out();
    w = bus.ex_mdu && !bus.mdu_done;
`ifdef PIPE_CTRL_PERF_EN
    if (!m_halt && !o[8] && m_cnt < 65535) m_cnt++;
`endif
    if (m_halt) begin
      if (!bus.stop) m_halt = 1'b0;
    end else if (m_drain > 0) begin
      if (!w) begin
        if (m_drain == 1) m_halt = 1'b1;
        m_drain--;
      end
    end else if (!w && bus.stop) m_drain = DC;
  endtask
  task automatic model_reset();
    m_drain = 0;
    m_halt  = 1'b0;
    m_cnt   = 0;
  endtask
  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (pc,ifid,idex,exma,marw,iff,idf,bub,halt)", nm, act, exp);
    end
  endtask
  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: stall_cnt got %h want %h", nm, act, exp);
    end
  endtask
  task automatic set_in(input logic ld, mdu, done, br, u1, u2, input logic [3:0] rs1, rs2, rd, input logic stp);
    bus.ex_load = ld; bus.ex_mdu = mdu; bus.mdu_done = done; bus.branch_taken = br;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.ex_rd = rd; bus.stop = stp;
  endtask
  task automatic step(input string nm, input bit he, input logic [8:0] exp);
    #3;
    chk(nm, dut_out(), model_out());
    if (he) chk({nm, "_exp"}, dut_out(), exp);
    chk16({nm, "_cnt"}, bus.stall_cnt, 16'(m_cnt));
    @(posedge clk);
    model_tick();
    #1;
  endtask
  initial begin
    vec_t tbl[12];
    tbl[0]  = '{0,0,0,0,0,0, 4'd0, 4'd0, 4'd5, N};
    tbl[1]  = '{1,0,0,0,1,0, 4'd5, 4'd0, 4'd5, HZ};
    tbl[2]  = '{1,0,0,0,0,1, 4'd2, 4'd5, 4'd5, HZ};
    tbl[3]  = '{1,0,0,0,0,0, 4'd5, 4'd5, 4'd5, N};
    tbl[4]  = '{1,0,0,0,1,1, 4'd4, 4'd6, 4'd5, N};
    tbl[5]  = '{0,0,0,0,1,1, 4'd5, 4'd5, 4'd5, N};
    tbl[6]  = '{1,0,0,1,1,0, 4'd5, 4'd0, 4'd5, BR};
    tbl[7]  = '{0,0,0,1,0,0, 4'd0, 4'd0, 4'd5, BR};
    tbl[8]  = '{0,1,0,0,0,0, 4'd0, 4'd0, 4'd5, MW};
    tbl[9]  = '{0,1,0,1,0,0, 4'd0, 4'd0, 4'd5, MW};
    tbl[10] = '{0,1,1,0,0,0, 4'd0, 4'd0, 4'd5, N};
    tbl[11] = '{1,1,1,0,1,0, 4'd5, 4'd0, 4'd5, HZ};
    set_in(0,0,0,0,0,0, 4'd0, 4'd0, 4'd0, 0);
    #2;
    chk("reset_outs", dut_out(), N);
    chk16("reset_cnt", bus.stall_cnt, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].ld, tbl[i].mdu, tbl[i].done, tbl[i].br, tbl[i].u1, tbl[i].u2,
             tbl[i].rs1, tbl[i].rs2, tbl[i].rd, 0);
      step($sformatf("vec%0d", i), 1, tbl[i].exp);
    end
    set_in(0,0,0,0,0,0, 4'd0, 4'd0, 4'd0, 0);
    step("idle", 1, N);
    for (int i = 0; i < 3; i++) begin
      set_in(0,1,0,0,0,0, 4'd0, 4'd0, 4'd0, 0);
      step($sformatf("mdu_wait%0d", i), 1, MW);
    end
    set_in(0,1,1,0,0,0, 4'd0, 4'd0, 4'd0, 0);
    step("mdu_done", 1, N);
    set_in(0,0,0,0,0,0, 4'd0, 4'd0, 4'd0, 0);
    step("mdu_after", 1, N);
    set_in(0,0,0,0,0,0, 4'd0, 4'd0, 4'd0, 1);
    step("stop_run", 1, N);
    for (int i = 0; i < DC; i++) step($sformatf("drain%0d", i), 1, DR);
    step("halt0", 1, HL);
    step("halt1", 1, HL);
    bus.stop = 1'b0;
    step("halt_exit", 1, HL);
    step("resume", 1, N);
    bus.stop = 1'b1;
    step("stop2", 1, N);
    bus.stop = 1'b0;
    step("drain_a", 1, DR);
    step("drain_b", 1, DR);
    rst = 1'b0;
    #1;
    chk("async_rst_outs", dut_out(), N);
    chk16("async_rst_cnt", bus.stall_cnt, 16'h0000);
    model_reset();
    #2 rst = 1'b1;
    step("post_rst0", 1, N);
    step("post_rst1", 1, N);
    set_in(0,1,0,0,0,0, 4'd0, 4'd0, 4'd0, 0);
    step("mdu_pre_rst", 1, MW);
    set_in(0,0,0,0,0,0, 4'd0, 4'd0, 4'd0, 0);
    rst = 1'b0;
    #1;
    chk("mdu_rst_outs", dut_out(), N);
    model_reset();
    #2 rst = 1'b1;
    step("mdu_post_rst", 1, N);
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0);
      step("rand", 0, '0);
    end
`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b0;
    model_reset();
    set_in(1,0,0,0,1,0, 4'd5, 4'd0, 4'd5, 0);
    #2 rst = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk16("perf_sat", bus.stall_cnt, 16'hFFFF);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter REG_BITS, default 4, register-specifier width.
REQ-002 SHALL provide parameter DRAIN_CYCLES, default 4, bubble cycles needed to empty IF/ID..MA/RW.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have ports id_rs1, id_rs2  input  REG_BITS  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs1, id_use_rs2  input  1  each set when the ID instruction reads that source.
REQ-007 SHALL have ports ex_load, ex_mdu  input  1  each set when the EX instruction is a load / a mul-div.
REQ-008 SHALL have port ex_rd  input  REG_BITS  destination register of the EX instruction.
REQ-009 SHALL have ports mdu_done, branch_taken, stop  input  1  mul-div result ready, taken branch resolved in EX, halt request.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exma_en, marw_en  output  1  pipeline register enables.
REQ-011 SHALL have ports ifid_flush, idex_flush, exma_bubble  output  1  insert a NOP into IF/ID, ID/EX, EX/MA respectively.
REQ-012 SHALL have ports halted  output  1 and stall_cnt  output  16  (perf counter, REQ-029).

Function
REQ-013 SHALL implement states RUN, MDU, DRAIN, HALT in a 2-bit state register; outputs combinational from state and inputs.
REQ-014 SHALL define hazard = ex_load & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-015 SHALL define mdu_wait = ex_mdu & ~mdu_done.
REQ-016 SHALL apply priority per cycle: mdu_wait > branch_taken > hazard > normal.
REQ-017 Normal (RUN): all five enables 1, all flush/bubble 0.
REQ-018 hazard: pc_en=0, ifid_en=0, idex_flush=1, idex_en/exma_en/marw_en=1; exactly one stall cycle per hazard occurrence.
REQ-019 branch_taken: pc_en=1, ifid_flush=1, idex_flush=1, other enables 1; hazard in same cycle SHALL be ignored.
REQ-020 mdu_wait (RUN or MDU): pc_en/ifid_en/idex_en=0, exma_bubble=1, exma_en=1, marw_en=1; next state MDU; branch_taken ignored.
REQ-021 MDU: remain while mdu_wait; in the cycle mdu_done=1, outputs per REQ-017 and next state RUN (or DRAIN if stop=1). ex_mdu & mdu_done in RUN SHALL cause zero stall cycles.
REQ-022 RUN with stop=1 and no mdu_wait: next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-023 DRAIN: pc_en=0, ifid_flush=1 every cycle; REQ-018..020 still apply to downstream stages; counter decrements each cycle except mdu_wait cycles (frozen); at counter==1 next state HALT.
REQ-024 HALT: all enables 0, all flush/bubble 0, halted=1; stop=0 -> RUN next cycle. stop dropped during DRAIN SHALL NOT abort the drain.
REQ-025 halted SHALL be 1 only in HALT.

Reset
REQ-026 rst=0 SHALL immediately force state RUN, drain counter 0, stall_cnt 0, independent of clk.
REQ-027 With rst=0 and all data inputs 0: pc_en..marw_en=1, ifid_flush/idex_flush/exma_bubble=0, halted=0.
REQ-028 Reset asserted mid-DRAIN or mid-MDU SHALL abandon that operation; first post-reset edge evaluates from RUN.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cnt increments on each clk edge where pc_en==0 and state!=HALT, saturating at 0xFFFF.
REQ-030 Macro PIPE_CTRL_PERF_EN undefined: stall_cnt tied to 16'h0000, no counter register synthesized.

Verification
REQ-031 RUN, ex_load=1, ex_rd=5, id_use_rs1=1, id_rs1=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; stall_cnt +1 (PERF).
REQ-032 Same as REQ-031 plus branch_taken=1 -> pc_en=1, ifid_flush=1, idex_flush=1, no stall.
REQ-033 ex_mdu=1, mdu_done asserted 3 cycles later -> 3 cycles of pc_en=0, exma_bubble=1, state MDU; 4th cycle all enables 1, state RUN.
REQ-034 stop=1 held in RUN, DRAIN_CYCLES=4 -> 4 cycles pc_en=0, ifid_flush=1, then halted=1 and all enables 0; stop=0 -> RUN next cycle.
REQ-035 rst driven 0 asynchronously two cycles into DRAIN -> state RUN, halted=0, stall_cnt=0 without a clock edge.
REQ-036 PERF build, 70000 consecutive hazard cycles -> stall_cnt=0xFFFF, no wrap.
